// File: rtl/jk_bank_pkg.sv
// Shared encodings for the JK bank controller: operation codes, FSM states
// and J/K pair values.
package jk_bank_pkg;

   typedef enum logic [1:0] {
      OP_HOLD   = 2'b00,
      OP_CLEAR  = 2'b01,
      OP_SET    = 2'b10,
      OP_TOGGLE = 2'b11
   } op_e;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] EXEC = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   // {j,k} pairs; op codes share this bit layout so op[1]=j, op[0]=k.
   localparam logic [1:0] JK_HOLD   = 2'b00;
   localparam logic [1:0] JK_CLEAR  = 2'b01;
   localparam logic [1:0] JK_SET    = 2'b10;
   localparam logic [1:0] JK_TOGGLE = 2'b11;

endpackage

// File: rtl/jk_bank_ctrl_if.sv
// Command channel of the JK bank controller: valid/ready handshake plus
// operation, bit mask and repeat count.
interface jk_bank_ctrl_if #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 4
);
   logic             cmd_valid;
   logic             cmd_ready;
   logic [1:0]       cmd_op;
   logic [WIDTH-1:0] cmd_mask;
   logic [CNT_W-1:0] cmd_rep;

   modport master (output cmd_valid, cmd_op, cmd_mask, cmd_rep, input cmd_ready);
   modport slave  (input cmd_valid, cmd_op, cmd_mask, cmd_rep, output cmd_ready);
endinterface

// File: rtl/jk_cell.sv
// Single JK flip-flop: rising edge, asynchronous active-high reset to 0.
module jk_cell
   import jk_bank_pkg::*;
(
   input  logic clk,
   input  logic reset,
   input  logic j_i,
   input  logic k_i,
   output logic q_o
);
   logic q_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         q_q <= 1'b0;
      end else begin
         case ({j_i, k_i})
            JK_CLEAR:  q_q <= 1'b0;
            JK_SET:    q_q <= 1'b1;
            JK_TOGGLE: q_q <= ~q_q;
            default:   q_q <= q_q;
         endcase
      end
   end

   assign q_o = q_q;
endmodule

// File: rtl/jk_bank_ctrl.sv
// Command sequencer driving a bank of WIDTH JK cells for cmd_rep+1 edges.
// Optional saturating bit-change counter enabled by JK_BANK_TOGGLE_CNT_EN.
module jk_bank_ctrl
   import jk_bank_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             reset,
   jk_bank_ctrl_if.slave    cmd,
   output logic [WIDTH-1:0] q,
   output logic             busy,
   output logic             done
`ifdef JK_BANK_TOGGLE_CNT_EN
   ,
   output logic [15:0]      toggle_cnt
`endif
);
   logic [1:0]       state_q, state_d;
   logic [1:0]       op_q, op_d;
   logic [WIDTH-1:0] mask_q, mask_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] j_vec, k_vec;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         op_q    <= OP_HOLD;
         mask_q  <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         mask_q  <= mask_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      mask_d  = mask_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (cmd.cmd_valid) begin
               state_d = EXEC;
               op_d    = cmd.cmd_op;
               mask_d  = cmd.cmd_mask;
               cnt_d   = cmd.cmd_rep;
            end
         end
         EXEC: begin
            if (cnt_q == '0) state_d = DONE;
            else             cnt_d   = cnt_q - CNT_W'(1);
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign cmd.cmd_ready = (state_q == IDLE);
   assign busy          = (state_q == EXEC) || (state_q == DONE);
   assign done          = (state_q == DONE);

   // Op code bits double as the J/K pair, so decode is just a masked broadcast.
   assign j_vec = (state_q == EXEC) ? (mask_q & {WIDTH{op_q[1]}}) : '0;
   assign k_vec = (state_q == EXEC) ? (mask_q & {WIDTH{op_q[0]}}) : '0;

   for (genvar i = 0; i < WIDTH; i++) begin : g_cell
      jk_cell u_cell (
         .clk   (clk),
         .reset (reset),
         .j_i   (j_vec[i]),
         .k_i   (k_vec[i]),
         .q_o   (q[i])
      );
   end

`ifdef JK_BANK_TOGGLE_CNT_EN
   logic [15:0]      tc_q, tc_d;
   logic [WIDTH-1:0] q_next;
   logic [15:0]      n_chg;

   function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [15:0] b);
      logic [16:0] sum;
      sum = {1'b0, a} + {1'b0, b};
      return sum[16] ? 16'hFFFF : sum[15:0];
   endfunction

   always_comb begin
      q_next = (j_vec & ~q) | (~k_vec & q);
      n_chg  = '0;
      for (int i = 0; i < WIDTH; i++) n_chg = n_chg + 16'(q_next[i] ^ q[i]);
      tc_d = sat_add16(tc_q, n_chg);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) tc_q <= '0;
      else       tc_q <= tc_d;
   end

   assign toggle_cnt = tc_q;
`endif
endmodule

// File: doc/jk_bank_ctrl.md
Name: jk_bank_ctrl

Overview:
- Command-driven sequencer for a bank of WIDTH JK flip-flops.
- Accepts operations via a valid/ready handshake: HOLD, CLEAR, SET or TOGGLE, applied to a masked subset of bits for a programmable number of clock edges.
- Drives the per-bit J/K inputs and reports busy/done status.
- Sits between a register-programming front end and any logic consuming the JK bank's state.

Parameters:
- WIDTH, 8, number of JK bits in the bank.
- CNT_W, 4, width of the repeat-count field; maximum repeat is 2^CNT_W edges.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  controller can accept a command.
- cmd_op  input  2  operation code: 00 HOLD, 01 CLEAR (j=0,k=1), 10 SET (j=1,k=0), 11 TOGGLE (j=1,k=1).
- cmd_mask  input  WIDTH  bits the operation applies to; unmasked bits get j=k=0.
- cmd_rep  input  CNT_W  operation applied for cmd_rep+1 consecutive edges.
- q  output  WIDTH  JK bank state.
- busy  output  1  high while in EXEC or DONE.
- done  output  1  one-cycle pulse at command completion.

Behaviour:
- Reset values: q=0, state=IDLE, busy=0, done=0, latched op/mask/count=0, cmd_ready=1 (combinational from IDLE).
- FSM states and transitions:
  - IDLE: cmd_ready=1. On a rising edge with cmd_valid=1, latch op, mask and rep into the counter, then go to EXEC.
  - EXEC: cmd_ready=0, busy=1. J/K for each bit are decoded combinationally from the latched op and mask. The JK cells update on every edge. At each edge: if counter==0, go to DONE; else decrement the counter.
  - DONE: done=1, busy=1, cmd_ready=0. The J/K inputs are held at 00. Go to IDLE on the next edge.
- Latency:
  - Accept edge is t. The op is applied at edges t+1 through t+1+rep.
  - done is high in the cycle following the last apply edge.
  - The next command can be accepted on the edge that leaves DONE+1, i.e. while in IDLE.
- Boundary conditions:
  - TOGGLE with rep+1 odd inverts the masked bits; with rep+1 even, the bits end unchanged.
  - mask=0: full timing still runs, q is unchanged and done still pulses.
  - HOLD: j=k=0 on all bits, so q is unchanged; the FSM still consumes rep+1 cycles (usable as a delay).
  - rep = all-ones: 2^CNT_W apply edges, with no counter wrap.
  - cmd_valid while busy is ignored; the sender holds valid until it sees ready (standard valid/ready rules).
  - Reset asserted mid-command: q=0 and IDLE immediately, with no done pulse. The command is lost.
  - Reset deasserted with cmd_valid=1: the command is accepted on the first rising edge after deassertion.

Optional Feature:
- Macro: JK_BANK_TOGGLE_CNT_EN.
- With the macro defined:
  - Extra output toggle_cnt (16 bits).
  - At each edge, adds the number of bits of q that changed.
  - Saturates at 0xFFFF and is cleared only by reset.
- Without the macro: the port and counter logic are absent, with no other behavioural change.

Decomposition:
- Package jk_bank_pkg holds:
  - op encodings: OP_HOLD, OP_CLEAR, OP_SET, OP_TOGGLE;
  - the FSM state enum: IDLE, EXEC, DONE;
  - the J/K pair encodings.
- Sub-module jk_cell:
  - a single JK flip-flop (rising edge, asynchronous active-high reset to 0);
  - 00 hold, 01 clear, 10 set, 11 toggle;
  - instantiated WIDTH times via generate.
- The FSM, counter and J/K decode live in the top level.

Test Plan:
- Reset at any time: q=0x00, cmd_ready=1, busy=0, done=0.
- From q=0x00, SET mask=0xF0 rep=0: q=0xF0 after 1 edge; done high the next cycle; cmd_ready back to 1 one edge later.
- From q=0xF0, TOGGLE mask=0x0F rep=2: busy for 4 cycles (3 EXEC + DONE), q=0xFF at end; with the macro, toggle_cnt=12 (assuming the count was 0 before this command).
- From q=0xFF, CLEAR mask=0x30 rep=0: q=0xCF. Then HOLD mask=0xFF rep=3: q stays 0xCF, done after 4 EXEC cycles.
- TOGGLE mask=0xFF rep=15, reset pulsed on the 5th EXEC cycle: q=0x00 asynchronously, state IDLE, no done pulse.
- cmd_valid held high with two queued commands: the second is accepted only in IDLE after done; cmd_ready=0 throughout EXEC/DONE; both commands complete in order.
